// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer
// Brief    : Microcode sequencer for the 8-bit shared-bus CPU. It steps a
//            registered T-state counter and decodes the IR opcode into
//            per-function control lines.
//            Optional macro SEQ_EARLY_END_EN: when defined, each instruction
//            returns to T0 right after its last active step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
    parameter int STEP_WIDTH = 3,
    parameter int LAST_STEP  = 4
) (
    input  logic                  i_CLOCK,
    input  logic                  i_RESET,
    input  logic                  i_ENABLE,
    input  logic [3:0]            i_OPCODE,
    input  logic                  i_CARRY,
    input  logic                  i_ZERO,
    output logic                  o_PC_OUT,
    output logic                  o_PC_COUNT,
    output logic                  o_PC_JUMP,
    output logic                  o_MAR_IN,
    output logic                  o_RAM_OUT,
    output logic                  o_RAM_IN,
    output logic                  o_IR_IN,
    output logic                  o_IR_OUT,
    output logic                  o_A_IN,
    output logic                  o_A_OUT,
    output logic                  o_B_IN,
    output logic                  o_ALU_OUT,
    output logic                  o_ALU_SUB,
    output logic                  o_FLAGS_IN,
    output logic                  o_OUT_IN,
    output logic                  o_HALT,
    output logic [STEP_WIDTH-1:0] o_STEP
);

    localparam logic [3:0] c_OP_NOP = 4'h0;
    localparam logic [3:0] c_OP_LDA = 4'h1;
    localparam logic [3:0] c_OP_ADD = 4'h2;
    localparam logic [3:0] c_OP_SUB = 4'h3;
    localparam logic [3:0] c_OP_STA = 4'h4;
    localparam logic [3:0] c_OP_LDI = 4'h5;
    localparam logic [3:0] c_OP_JMP = 4'h6;
    localparam logic [3:0] c_OP_JC  = 4'h7;
    localparam logic [3:0] c_OP_JZ  = 4'h8;
    localparam logic [3:0] c_OP_OUT = 4'hE;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    localparam logic [STEP_WIDTH-1:0] c_T0   = STEP_WIDTH'(0);
    localparam logic [STEP_WIDTH-1:0] c_T1   = STEP_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] c_T2   = STEP_WIDTH'(2);
    localparam logic [STEP_WIDTH-1:0] c_T3   = STEP_WIDTH'(3);
    localparam logic [STEP_WIDTH-1:0] c_T4   = STEP_WIDTH'(4);
    localparam logic [STEP_WIDTH-1:0] c_LAST = STEP_WIDTH'(LAST_STEP);

    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic                  halted_q, halted_d;
    logic                  w_wrap;

`ifdef SEQ_EARLY_END_EN
    logic [STEP_WIDTH-1:0] w_end_step;

    always_comb begin
        w_end_step = c_T1;
        case (i_OPCODE)
            c_OP_LDI, c_OP_JMP, c_OP_JC, c_OP_JZ, c_OP_OUT: w_end_step = c_T2;
            c_OP_LDA, c_OP_STA:                             w_end_step = c_T3;
            c_OP_ADD, c_OP_SUB:                             w_end_step = c_T4;
            c_OP_HLT:                                       w_end_step = c_T2;
            default:                                        w_end_step = c_T1;
        endcase
    end

    // The opcode end step is only meaningful from T1 on; T0 always advances.
    assign w_wrap = (step_q >= c_LAST) || ((step_q != c_T0) && (step_q == w_end_step));
`else
    assign w_wrap = (step_q >= c_LAST);
`endif

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (i_ENABLE && !halted_q) begin
            if ((step_q == c_T2) && (i_OPCODE == c_OP_HLT)) begin
                halted_d = 1'b1;
            end else if (w_wrap) begin
                step_d = c_T0;
            end else begin
                step_d = step_q + c_T1;
            end
        end
    end

    always_ff @(posedge i_CLOCK) begin
        if (i_RESET) begin
            step_q   <= c_T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        o_PC_OUT   = 1'b0;
        o_PC_COUNT = 1'b0;
        o_PC_JUMP  = 1'b0;
        o_MAR_IN   = 1'b0;
        o_RAM_OUT  = 1'b0;
        o_RAM_IN   = 1'b0;
        o_IR_IN    = 1'b0;
        o_IR_OUT   = 1'b0;
        o_A_IN     = 1'b0;
        o_A_OUT    = 1'b0;
        o_B_IN     = 1'b0;
        o_ALU_OUT  = 1'b0;
        o_ALU_SUB  = 1'b0;
        o_FLAGS_IN = 1'b0;
        o_OUT_IN   = 1'b0;
        if (!i_RESET && i_ENABLE && !halted_q) begin
            case (step_q)
                c_T0: begin
                    o_PC_OUT = 1'b1;
                    o_MAR_IN = 1'b1;
                end
                c_T1: begin
                    o_RAM_OUT  = 1'b1;
                    o_IR_IN    = 1'b1;
                    o_PC_COUNT = 1'b1;
                end
                c_T2: begin
                    case (i_OPCODE)
                        c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
                            o_IR_OUT = 1'b1;
                            o_MAR_IN = 1'b1;
                        end
                        c_OP_LDI: begin
                            o_IR_OUT = 1'b1;
                            o_A_IN   = 1'b1;
                        end
                        c_OP_JMP: begin
                            o_IR_OUT  = 1'b1;
                            o_PC_JUMP = 1'b1;
                        end
                        c_OP_JC: begin
                            o_IR_OUT  = 1'b1;
                            o_PC_JUMP = i_CARRY;
                        end
                        c_OP_JZ: begin
                            o_IR_OUT  = 1'b1;
                            o_PC_JUMP = i_ZERO;
                        end
                        c_OP_OUT: begin
                            o_A_OUT  = 1'b1;
                            o_OUT_IN = 1'b1;
                        end
                        default: ;
                    endcase
                end
                c_T3: begin
                    case (i_OPCODE)
                        c_OP_LDA: begin
                            o_RAM_OUT = 1'b1;
                            o_A_IN    = 1'b1;
                        end
                        c_OP_ADD, c_OP_SUB: begin
                            o_RAM_OUT = 1'b1;
                            o_B_IN    = 1'b1;
                        end
                        c_OP_STA: begin
                            o_A_OUT  = 1'b1;
                            o_RAM_IN = 1'b1;
                        end
                        default: ;
                    endcase
                end
                c_T4: begin
                    if ((i_OPCODE == c_OP_ADD) || (i_OPCODE == c_OP_SUB)) begin
                        o_ALU_OUT  = 1'b1;
                        o_A_IN     = 1'b1;
                        o_FLAGS_IN = 1'b1;
                        o_ALU_SUB  = (i_OPCODE == c_OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_HALT = halted_q && !i_RESET;
    assign o_STEP = step_q;

    // NOP is named for decode readability only; it shares the default arm.
    logic w_unused;
    assign w_unused = (c_OP_NOP == 4'h0);

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module   : tb_control_sequencer
// Brief    : Directed self-checking bench for control_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] op;
    logic       carry;
    logic       zero;

    logic pc_out, pc_count, pc_jump, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halt;
    logic [2:0] step;

    int checks = 0;
    int errors = 0;

    // Control vector bit positions, MSB first in the concatenation below
    localparam logic [14:0] PCO = 15'h4000;
    localparam logic [14:0] PCC = 15'h2000;
    localparam logic [14:0] PCJ = 15'h1000;
    localparam logic [14:0] MAR = 15'h0800;
    localparam logic [14:0] RMO = 15'h0400;
    localparam logic [14:0] RMI = 15'h0200;
    localparam logic [14:0] IRI = 15'h0100;
    localparam logic [14:0] IRO = 15'h0080;
    localparam logic [14:0] AI  = 15'h0040;
    localparam logic [14:0] AO  = 15'h0020;
    localparam logic [14:0] BI  = 15'h0010;
    localparam logic [14:0] ALO = 15'h0008;
    localparam logic [14:0] SUB = 15'h0004;
    localparam logic [14:0] FLI = 15'h0002;
    localparam logic [14:0] OUI = 15'h0001;
    localparam logic [14:0] NONE = 15'h0000;
    localparam logic [14:0] FT0 = PCO | MAR;
    localparam logic [14:0] FT1 = RMO | IRI | PCC;

    logic [14:0] ctl;
    assign ctl = {pc_out, pc_count, pc_jump, mar_in, ram_out, ram_in, ir_in, ir_out,
                  a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in};

    control_sequencer #(.STEP_WIDTH(3), .LAST_STEP(4)) dut (
        .i_CLOCK   (clk),
        .i_RESET   (rst),
        .i_ENABLE  (en),
        .i_OPCODE  (op),
        .i_CARRY   (carry),
        .i_ZERO    (zero),
        .o_PC_OUT  (pc_out),
        .o_PC_COUNT(pc_count),
        .o_PC_JUMP (pc_jump),
        .o_MAR_IN  (mar_in),
        .o_RAM_OUT (ram_out),
        .o_RAM_IN  (ram_in),
        .o_IR_IN   (ir_in),
        .o_IR_OUT  (ir_out),
        .o_A_IN    (a_in),
        .o_A_OUT   (a_out),
        .o_B_IN    (b_in),
        .o_ALU_OUT (alu_out),
        .o_ALU_SUB (alu_sub),
        .o_FLAGS_IN(flags_in),
        .o_OUT_IN  (out_in),
        .o_HALT    (halt),
        .o_STEP    (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [14:0] exp);
        checks++;
        assert (ctl === exp) else begin
            errors++;
            $error("FAIL %s ctl observed=%h expected=%h", tag, ctl, exp);
        end
    endtask

    task automatic chk_step(input string tag, input logic [2:0] exp);
        checks++;
        assert (step === exp) else begin
            errors++;
            $error("FAIL %s step observed=%0d expected=%0d", tag, step, exp);
        end
    endtask

    task automatic chk_halt(input string tag, input logic exp);
        checks++;
        assert (halt === exp) else begin
            errors++;
            $error("FAIL %s halt observed=%b expected=%b", tag, halt, exp);
        end
    endtask

    // Runs one full fixed-length instruction starting at T0 and checks T0..T4
    task automatic run_instr(input string tag, input logic [3:0] opc,
                             input logic [14:0] e2, input logic [14:0] e3,
                             input logic [14:0] e4);
        op = opc;
        #1;
        chk_step({tag, "_t0"}, 3'd0); chk_ctl({tag, "_t0"}, FT0); cyc();
        chk_step({tag, "_t1"}, 3'd1); chk_ctl({tag, "_t1"}, FT1); cyc();
        chk_step({tag, "_t2"}, 3'd2); chk_ctl({tag, "_t2"}, e2);  cyc();
        chk_step({tag, "_t3"}, 3'd3); chk_ctl({tag, "_t3"}, e3);  cyc();
        chk_step({tag, "_t4"}, 3'd4); chk_ctl({tag, "_t4"}, e4);  cyc();
        chk_step({tag, "_wrap"}, 3'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; op = 4'h0; carry = 1'b0; zero = 1'b0;
        cyc();
        en = 1'b1;
        #1;
        chk_ctl("reset_ctl", NONE);
        chk_halt("reset_halt", 1'b0);
        chk_step("reset_step", 3'd0);
        rst = 1'b0;

`ifdef SEQ_EARLY_END_EN
        op = 4'h5; #1;
        chk_step("ldi_t0", 3'd0); chk_ctl("ldi_t0", FT0); cyc();
        chk_step("ldi_t1", 3'd1); chk_ctl("ldi_t1", FT1); cyc();
        chk_step("ldi_t2", 3'd2); chk_ctl("ldi_t2", IRO | AI); cyc();
        chk_step("ldi_end", 3'd0);
        op = 4'h0; #1;
        chk_ctl("nop_t0", FT0); cyc();
        chk_step("nop_t1", 3'd1); cyc();
        chk_step("nop_end", 3'd0);
        op = 4'h2; #1; cyc(); cyc(); cyc(); cyc();
        chk_step("add_t4", 3'd4); chk_ctl("add_t4", ALO | AI | FLI); cyc();
        chk_step("add_end", 3'd0);
        op = 4'h7; carry = 1'b0; #1; cyc(); cyc();
        chk_ctl("jc_nt_t2", IRO); cyc();
        chk_step("jc_nt_end", 3'd0);
`else
        run_instr("lda", 4'h1, IRO | MAR, RMO | AI, NONE);
        run_instr("add", 4'h2, IRO | MAR, RMO | BI, ALO | AI | FLI);
        run_instr("sub", 4'h3, IRO | MAR, RMO | BI, ALO | AI | FLI | SUB);
        run_instr("sta", 4'h4, IRO | MAR, AO | RMI, NONE);
        run_instr("ldi", 4'h5, IRO | AI, NONE, NONE);
        run_instr("jmp", 4'h6, IRO | PCJ, NONE, NONE);
        carry = 1'b0;
        run_instr("jc_nt", 4'h7, IRO, NONE, NONE);
        carry = 1'b1;
        run_instr("jc_t", 4'h7, IRO | PCJ, NONE, NONE);
        carry = 1'b0;
        zero = 1'b0;
        run_instr("jz_nt", 4'h8, IRO, NONE, NONE);
        zero = 1'b1;
        run_instr("jz_t", 4'h8, IRO | PCJ, NONE, NONE);
        zero = 1'b0;
        run_instr("out", 4'hE, AO | OUI, NONE, NONE);
        run_instr("nop", 4'h0, NONE, NONE, NONE);
        run_instr("undef", 4'hB, NONE, NONE, NONE);

        // Pause during T1
        op = 4'h1; #1; cyc();
        chk_step("pause_pre", 3'd1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_step("pause_step", 3'd1);
            chk_ctl("pause_ctl", NONE);
            cyc();
        end
        en = 1'b1; #1;
        chk_step("resume_t1", 3'd1); chk_ctl("resume_t1", FT1); cyc();
        chk_step("resume_t2", 3'd2); chk_ctl("resume_t2", IRO | MAR); cyc(); cyc(); cyc();
        chk_step("resume_wrap", 3'd0);

        // Reset in the middle of ADD at T3
        op = 4'h2; #1; cyc(); cyc(); cyc();
        chk_step("rst_mid_t3", 3'd3);
        rst = 1'b1; #1;
        chk_ctl("rst_mid_mask", NONE);
        cyc();
        rst = 1'b0; #1;
        chk_step("rst_mid_step", 3'd0); chk_ctl("rst_mid_ctl", FT0);
`endif

        // Halt, then recover through reset
        op = 4'hF; #1; cyc(); cyc();
        chk_step("hlt_t2", 3'd2); chk_ctl("hlt_t2", NONE); chk_halt("hlt_t2", 1'b0);
        cyc();
        for (int i = 0; i < 20; i++) begin
            chk_halt("halted", 1'b1);
            chk_ctl("halted_ctl", NONE);
            cyc();
        end
        rst = 1'b1; #1;
        chk_halt("hlt_rst_mask", 1'b0);
        cyc();
        rst = 1'b0; op = 4'h1; #1;
        chk_step("hlt_rst_step", 3'd0); chk_halt("hlt_rst_halt", 1'b0);
        chk_ctl("hlt_rst_ctl", FT0);

        // Random opcode run: bus exclusivity and PC count/jump exclusivity
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 14));
            carry = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            #1;
            checks++;
            assert ($onehot0({pc_out, ram_out, ir_out, a_out, alu_out})) else begin
                errors++;
                $error("FAIL bus_drivers observed=%b expected=onehot0",
                       {pc_out, ram_out, ir_out, a_out, alu_out});
            end
            checks++;
            assert (!(pc_jump && pc_count)) else begin
                errors++;
                $error("FAIL pc_jump_count observed=%b%b expected=not both", pc_jump, pc_count);
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode sequencer for the 8-bit shared-bus CPU. It drives the program counter, memory address register, RAM, instruction register, A/B registers, ALU, flags and output register.
- Steps through fetch/execute T-states from a registered step counter. It decodes the IR opcode into a one-hot-per-function control word, so every bus transfer is commanded from this single block.

Parameters:
- STEP_WIDTH, 3, width of step counter and o_STEP.
- LAST_STEP, 4, final T-state index in fixed-length mode; must be >= 4 and < 2**STEP_WIDTH.

Ports:
- i_CLOCK  input  1  system clock; all state changes on rising edge.
- i_RESET  input  1  synchronous, active-high reset.
- i_ENABLE  input  1  1 = sequencer runs; 0 = step frozen and all controls 0 (single-step/pause).
- i_OPCODE  input  4  IR[7:4], valid from T2 onward.
- i_CARRY  input  1  carry flag from flags register.
- i_ZERO  input  1  zero flag from flags register.
- o_PC_OUT, o_PC_COUNT, o_PC_JUMP  output  1 each  program counter output/increment/load.
- o_MAR_IN  output  1  MAR loads bus.
- o_RAM_OUT, o_RAM_IN  output  1 each  RAM drive/write.
- o_IR_IN, o_IR_OUT  output  1 each  IR load; IR drives operand IR[3:0] on bus.
- o_A_IN, o_A_OUT, o_B_IN  output  1 each  register A load/drive, register B load.
- o_ALU_OUT, o_ALU_SUB  output  1 each  ALU drives bus; subtract select.
- o_FLAGS_IN, o_OUT_IN  output  1 each  flags latch; output register load.
- o_HALT  output  1  CPU halted.
- o_STEP  output  STEP_WIDTH  current T-state.

Behaviour:
- State: step counter plus HALTED bit, both registered. Control outputs are combinational from state, i_OPCODE and flags.
- Reset (sync, i_RESET=1 at an edge): step <= 0, HALTED <= 0.
  - While i_RESET=1, all control outputs and o_HALT are 0 regardless of state.
- i_ENABLE=0: step/HALTED hold; all control outputs 0; o_HALT reflects HALTED.
- Step advance, when enabled and not halted:
  - step <= step+1.
  - After LAST_STEP, wrap to 0.
- HALTED: all controls 0, o_HALT=1, step holds. Only reset exits this state.
- Bus rule: at most one of PC_OUT, RAM_OUT, IR_OUT, A_OUT, ALU_OUT is high in any cycle.
- Fetch, all opcodes:
  - T0: PC_OUT, MAR_IN.
  - T1: RAM_OUT, IR_IN, PC_COUNT.
- Execute, T2..T4 (unlisted steps drive nothing):
  - 0x0 NOP: none.
  - 0x1 LDA: T2 IR_OUT+MAR_IN; T3 RAM_OUT+A_IN.
  - 0x2 ADD: T2 IR_OUT+MAR_IN; T3 RAM_OUT+B_IN; T4 ALU_OUT+A_IN+FLAGS_IN.
  - 0x3 SUB: as ADD, with ALU_SUB also high in T4 only.
  - 0x4 STA: T2 IR_OUT+MAR_IN; T3 A_OUT+RAM_IN.
  - 0x5 LDI: T2 IR_OUT+A_IN.
  - 0x6 JMP: T2 IR_OUT+PC_JUMP.
  - 0x7 JC: T2 IR_OUT; PC_JUMP only if i_CARRY=1 (sampled in T2).
  - 0x8 JZ: T2 IR_OUT; PC_JUMP only if i_ZERO=1.
  - 0xE OUT: T2 A_OUT+OUT_IN.
  - 0xF HLT: in T2, controls 0; at the T2 edge HALTED <= 1. o_HALT is high from the next cycle.
  - 0x9-0xD: treated as NOP.
- PC_JUMP and PC_COUNT are never high in the same cycle.
- Reset during execute: the next cycle is T0 with no partial micro-op carried over.
- Flag changes in T3/T4 have no effect on an already-completed jump.

Optional Feature:
- Macro SEQ_EARLY_END_EN.
- Defined: after an opcode's last active step, step <= 0 instead of continuing. Last active steps:
  - NOP/undefined: T1.
  - LDI/JMP/JC/JZ/OUT: T2.
  - LDA/STA: T3.
  - ADD/SUB: T4.
  - A not-taken JC/JZ still ends at T2.
- Undefined: fixed-length cycle T0..LAST_STEP for every instruction; the idle steps drive nothing.

Test Plan:
- Reset then enable, opcode 0x1 presented from T2 -> o_STEP sequences 0,1,2,3,4,0 (fixed mode). Required controls:
  - T0: PC_OUT+MAR_IN; T1: RAM_OUT+IR_IN+PC_COUNT; T2: IR_OUT+MAR_IN; T3: RAM_OUT+A_IN; T4: none.
- Opcode 0x3 -> T4 has ALU_OUT+A_IN+FLAGS_IN+ALU_SUB=1, and ALU_SUB=0 in every other step.
- Opcode 0x7 with i_CARRY=0 -> T2 has IR_OUT=1, PC_JUMP=0. Repeat with i_CARRY=1 -> PC_JUMP=1. Same pair for 0x8 with i_ZERO.
- Opcode 0xF -> o_HALT=1 from the cycle after T2; all controls 0 for 20 further cycles. Then assert i_RESET one cycle -> o_STEP=0, o_HALT=0, T0 controls reappear.
- i_ENABLE=0 during T1 for 3 cycles -> o_STEP stays 1, PC_COUNT=0. Re-enable -> T1 controls once, then T2.
- Assert i_RESET at T3 of 0x2 -> next cycle o_STEP=0 with T0 controls.
- Every cycle of a random opcode run: at most one bus driver high.
- With SEQ_EARLY_END_EN: 0x5 gives steps 0,1,2,0 and 0x0 gives 0,1,0.
